vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator for the video output path: produces sync, data-enable and pixel coordinates for any mode described by its parameters (default 640×480@60 at a 25 MHz vga_pclk). It adds programmable sync polarity, line/frame start strobes, a run/stop control, and an optional pixel-prefetch request with its own coordinates. The prefetch request lets the frame-buffer reader fetch pixel data a fixed number of cycles ahead of display. It sits between the pixel-clock domain of the frame buffer reader and the VGA pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_F_PORCH, 16, horizontal front porch cycles
- H_SYNC, 96, hsync width cycles
- H_B_PORCH, 48, horizontal back porch cycles
- V_ACTIVE, 480; V_F_PORCH, 10; V_SYNC, 2; V_B_PORCH, 33: vertical equivalents in lines
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CNT_W, 12, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- PREFETCH, 4, pix_req lead in cycles; legal range 0..H_SYNC+H_B_PORCH
- vga_pclk  in  1  pixel clock
- sys_rst  in  1  reset, asynchronous, active-high
- timing_en  in  1  run enable; low holds generator in reset state
- vga_hsync  out  1  horizontal sync, level per HS_POL
- vga_vsync  out  1  vertical sync, level per VS_POL
- vga_de  out  1  active-video enable
- vga_x  out  CNT_W  active pixel column, 0..H_ACTIVE-1 when vga_de, else 0
- vga_y  out  CNT_W  active line, 0..V_ACTIVE-1 when vga_de, else 0
- line_start  out  1  one-cycle strobe at start of every line
- frame_start  out  1  one-cycle strobe at start of every frame
- pix_req  out  1  prefetch request, PREFETCH cycles ahead of vga_de
- req_x  out  CNT_W  column of requested pixel when pix_req, else 0
- req_y  out  CNT_W  line of requested pixel when pix_req, else 0

## Operation
- H_TOTAL = H_SYNC+H_B_PORCH+H_ACTIVE+H_F_PORCH; V_TOTAL likewise. HA0 = H_SYNC+H_B_PORCH, VA0 = V_SYNC+V_B_PORCH.
- Line order: sync, back porch, active, front porch (h_cnt 0..H_TOTAL-1). Frame order is the same (v_cnt 0..V_TOTAL-1).
- h_cnt increments every enabled cycle and wraps to 0 after H_TOTAL-1. v_cnt increments only on h wrap and wraps to 0 after V_TOTAL-1.
- Decodes, all registered from current counter values:
  - hsync active while h_cnt < H_SYNC; vsync active while v_cnt < V_SYNC.
  - de = (HA0 ≤ h_cnt < HA0+H_ACTIVE) && (VA0 ≤ v_cnt < VA0+V_ACTIVE).
  - vga_x = h_cnt-HA0 and vga_y = v_cnt-VA0 when de, else 0.
  - line_start when h_cnt==0; frame_start when h_cnt==0 && v_cnt==0.
- pix_req = v in active range && HA0-PREFETCH ≤ h_cnt < HA0-PREFETCH+H_ACTIVE. req_x = h_cnt-(HA0-PREFETCH), req_y = v_cnt-VA0. Because of the PREFETCH range limit, a request never crosses a line boundary.
- timing_en low: counters forced to 0 and all outputs forced to reset values on the next edge. Raising timing_en restarts from (0,0), so the first enabled output cycle carries frame_start.
- Subtractions are CNT_W unsigned. Coordinates are zeroed outside their valid windows, never wrapped values.

## Timing
- Reset values: counters 0; vga_hsync = ~HS_POL; vga_vsync = ~VS_POL; vga_de, line_start, frame_start, pix_req = 0; all coordinates 0.
- Latency: every output reflects the counter state one cycle earlier. All outputs are mutually aligned.
- Edge k after reset release (or after timing_en rises) presents counter value k-1. Edge 1 shows hsync/vsync active, line_start=1, frame_start=1.
- pix_req for pixel (x,y) is high exactly PREFETCH cycles before vga_de for (x,y). With PREFETCH=0 it equals vga_de.
- Reset mid-line: asynchronous return to reset values. No partial-line strobes follow.

## Configuration
- VGA_TIMING_PREFETCH_EN defined: pix_req, req_x and req_y are generated as specified.
- Undefined: pix_req, req_x and req_y are tied to 0, PREFETCH is ignored, and no prefetch logic is synthesised. The ports remain present.

## Test plan
- Defaults, release reset with timing_en=1 -> edge 1: frame_start=1, hsync=0, vsync=0. First vga_de=1 at edge 28145 with x=0, y=0. Last de at x=639, y=479.
- Defaults, run 2 frames -> frame_start period 420000 cycles, line_start period 800 cycles. hsync low 96 cycles per line, vsync low 1600 cycles per frame. Exactly 307200 de cycles per frame.
- HS_POL=1, VS_POL=1 -> sync pulses high with identical widths and positions. Reset value of both syncs is 0.
- VGA_TIMING_PREFETCH_EN with PREFETCH=4 -> pix_req first high at edge 28141 with req_x=0, req_y=0. Each pix_req cycle matches vga_de 4 cycles later with identical coordinates.
- timing_en dropped mid-frame at line 200 -> next edge all outputs are at reset values. On re-enable, edge 1 shows frame_start=1 and counting restarts from (0,0).
- sys_rst asserted asynchronously mid-active-video -> outputs go to reset values immediately, without waiting for a clock edge. After release the behaviour is identical to the first scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces registered hsync/vsync, data-enable, pixel coordinates and
// line/frame start strobes from a pair of free-running h/v counters.
// Line and frame order: sync, back porch, active, front porch.
// Optional feature macro: VGA_TIMING_PREFETCH_EN. When it is defined,
// pix_req/req_x/req_y lead vga_de by PREFETCH cycles. When it is not
// defined, these outputs are tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_F_PORCH = 16,
  parameter int H_SYNC    = 96,
  parameter int H_B_PORCH = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_F_PORCH = 10,
  parameter int V_SYNC    = 2,
  parameter int V_B_PORCH = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = 12,
  parameter int PREFETCH  = 4
) (
  input  logic             vga_pclk,
  input  logic             sys_rst,
  input  logic             timing_en,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_de,
  output logic [CNT_W-1:0] vga_x,
  output logic [CNT_W-1:0] vga_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             pix_req,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y
);

  localparam int H_TOTAL = H_SYNC + H_B_PORCH + H_ACTIVE + H_F_PORCH;
  localparam int V_TOTAL = V_SYNC + V_B_PORCH + V_ACTIVE + V_F_PORCH;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNCE = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNCE = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA0     = CNT_W'(H_SYNC + H_B_PORCH);
  localparam logic [CNT_W-1:0] HA1     = CNT_W'(H_SYNC + H_B_PORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] VA0     = CNT_W'(V_SYNC + V_B_PORCH);
  localparam logic [CNT_W-1:0] VA1     = CNT_W'(V_SYNC + V_B_PORCH + V_ACTIVE);

  // A lead larger than sync+back porch would make a request cross into
  // the previous line, which the reader cannot handle.
  if (PREFETCH < 0 || PREFETCH > H_SYNC + H_B_PORCH) begin : g_prefetch_range
    $error("vga_timing_gen: PREFETCH must be within 0..H_SYNC+H_B_PORCH");
  end

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_act, v_act;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Counter advance: h every enabled cycle, v on h wrap; disabled parks at (0,0).
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!timing_en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
    end
  end

  // Output decode from the current counters; disabled forces reset values.
  always_comb begin
    h_act         = (h_cnt_q >= HA0) && (h_cnt_q < HA1);
    v_act         = (v_cnt_q >= VA0) && (v_cnt_q < VA1);
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    de_d          = 1'b0;
    x_d           = '0;
    y_d           = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (timing_en) begin
      hsync_d       = (h_cnt_q < H_SYNCE) ? HS_POL : ~HS_POL;
      vsync_d       = (v_cnt_q < V_SYNCE) ? VS_POL : ~VS_POL;
      de_d          = h_act && v_act;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (h_act && v_act) begin
        x_d = h_cnt_q - HA0;
        y_d = v_cnt_q - VA0;
      end
    end
  end

  // Counter and output registers with asynchronous reset.
  always_ff @(posedge vga_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_de      = de_q;
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_PREFETCH_EN
  // The request window is the active window shifted PREFETCH cycles earlier
  // on the same line.
  localparam logic [CNT_W-1:0] R0 = CNT_W'(H_SYNC + H_B_PORCH - PREFETCH);
  localparam logic [CNT_W-1:0] R1 = CNT_W'(H_SYNC + H_B_PORCH - PREFETCH + H_ACTIVE);

  logic             req_q, req_d;
  logic [CNT_W-1:0] req_x_q, req_x_d;
  logic [CNT_W-1:0] req_y_q, req_y_d;

  // Prefetch window decode; coordinates are zero outside the window.
  always_comb begin
    req_d   = 1'b0;
    req_x_d = '0;
    req_y_d = '0;
    if (timing_en && v_act && (h_cnt_q >= R0) && (h_cnt_q < R1)) begin
      req_d   = 1'b1;
      req_x_d = h_cnt_q - R0;
      req_y_d = v_cnt_q - VA0;
    end
  end

  // Prefetch output registers, aligned with the display outputs.
  always_ff @(posedge vga_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      req_q   <= 1'b0;
      req_x_q <= '0;
      req_y_q <= '0;
    end else begin
      req_q   <= req_d;
      req_x_q <= req_x_d;
      req_y_q <= req_y_d;
    end
  end

  assign pix_req = req_q;
  assign req_x   = req_x_q;
  assign req_y   = req_y_q;
`else
  assign pix_req = 1'b0;
  assign req_x   = '0;
  assign req_y   = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster (15x9 cycles)
// so several frames fit in a short run. Expected outputs for every edge come
// from a cycle-index model and go through a scoreboard queue; scenario tasks
// add their own checks on periods, widths and first/last positions.
module tb_vga_timing_gen;

  localparam int CW  = 12;
  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 2;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;
  localparam int PF  = 3;

  localparam int HT    = HS + HBP + HA + HFP;
  localparam int VT    = VS + VBP + VA + VFP;
  localparam int HA0   = HS + HBP;
  localparam int VA0   = VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int FIRST_DE_EDGE = VA0 * HT + HA0 + 1;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          ls;
    logic          fs;
    logic          req;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] rx;
    logic [CW-1:0] ry;
  } out_t;

  logic          clk;
  logic          sys_rst;
  logic          timing_en;
  logic          vga_hsync, vga_vsync, vga_de, line_start, frame_start, pix_req;
  logic [CW-1:0] vga_x, vga_y, req_x, req_y;

  int   checks;
  int   errors;
  int   run_cnt;
  out_t sb_q[$];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_F_PORCH(HFP), .H_SYNC(HS), .H_B_PORCH(HBP),
    .V_ACTIVE(VA), .V_F_PORCH(VFP), .V_SYNC(VS), .V_B_PORCH(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(CW), .PREFETCH(PF)
  ) dut (
    .vga_pclk(clk), .sys_rst(sys_rst), .timing_en(timing_en),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
    .vga_x(vga_x), .vga_y(vga_y), .line_start(line_start),
    .frame_start(frame_start), .pix_req(pix_req), .req_x(req_x), .req_y(req_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t reset_val();
    out_t r;
    r    = '0;
    r.hs = ~HS_POL;
    r.vs = ~VS_POL;
    return r;
  endfunction

  // Expected outputs when the counters hold position n (cycles since start).
  function automatic out_t model(int n);
    out_t r;
    int   h, v;
    bit   va;
    r    = reset_val();
    h    = n % HT;
    v    = (n / HT) % VT;
    r.hs = (h < HS) ? HS_POL : ~HS_POL;
    r.vs = (v < VS) ? VS_POL : ~VS_POL;
    va   = (v >= VA0) && (v < VA0 + VA);
    r.de = va && (h >= HA0) && (h < HA0 + HA);
    if (r.de) begin
      r.x = CW'(h - HA0);
      r.y = CW'(v - VA0);
    end
    r.ls = (h == 0);
    r.fs = (h == 0) && (v == 0);
`ifdef VGA_TIMING_PREFETCH_EN
    if (va && (h + PF >= HA0) && (h + PF < HA0 + HA)) begin
      r.req = 1'b1;
      r.rx  = CW'(h + PF - HA0);
      r.ry  = CW'(v - VA0);
    end
`endif
    return r;
  endfunction

  function automatic out_t sample();
    out_t s;
    s.hs  = vga_hsync;
    s.vs  = vga_vsync;
    s.de  = vga_de;
    s.ls  = line_start;
    s.fs  = frame_start;
    s.req = pix_req;
    s.x   = vga_x;
    s.y   = vga_y;
    s.rx  = req_x;
    s.ry  = req_y;
    return s;
  endfunction

  // Drive one clock edge: predict its outputs, queue them, return at edge+2.
  task automatic step();
    out_t e;
    if (sys_rst || !timing_en) begin
      e       = reset_val();
      run_cnt = 0;
    end else begin
      e       = model(run_cnt);
      run_cnt = run_cnt + 1;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: compare each queued prediction 1 time unit after its edge.
  initial begin
    out_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = sample();
        checks = checks + 1;
        if (a !== e) begin
          errors = errors + 1;
          $display("FAIL sb_edge t=%0t got hs=%b vs=%b de=%b ls=%b fs=%b req=%b x=%0d y=%0d rx=%0d ry=%0d exp hs=%b vs=%b de=%b ls=%b fs=%b req=%b x=%0d y=%0d rx=%0d ry=%0d",
                   $time, a.hs, a.vs, a.de, a.ls, a.fs, a.req, a.x, a.y, a.rx, a.ry,
                   e.hs, e.vs, e.de, e.ls, e.fs, e.req, e.x, e.y, e.rx, e.ry);
        end
      end
    end
  end

  task automatic test_reset();
    out_t a;
    sys_rst   = 1'b1;
    timing_en = 1'b0;
    #3;
    a = sample();
    checks = checks + 1;
    if (a !== reset_val()) begin
      errors = errors + 1;
      $display("FAIL reset_async got %h exp %h", a, reset_val());
    end
    timing_en = 1'b1;
    step();
    step();
    a = sample();
    checks = checks + 1;
    if (a !== reset_val()) begin
      errors = errors + 1;
      $display("FAIL reset_held got %h exp %h", a, reset_val());
    end
    $display("test_reset done t=%0t", $time);
  endtask

  // Called with reset or timing_en just released/raised and the model at 0.
  task automatic test_first_frame();
    out_t a;
    int   first_de;
    logic [CW-1:0] fx, fy, lx, ly;
    first_de = -1;
    fx = '1; fy = '1; lx = '1; ly = '1;
    sys_rst = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      step();
      a = sample();
      if (k == 1) begin
        checks = checks + 1;
        if (a.fs !== 1'b1 || a.ls !== 1'b1 || a.hs !== HS_POL || a.vs !== VS_POL) begin
          errors = errors + 1;
          $display("FAIL edge1 got fs=%b ls=%b hs=%b vs=%b exp fs=1 ls=1 hs=%b vs=%b",
                   a.fs, a.ls, a.hs, a.vs, HS_POL, VS_POL);
        end
      end
      if (a.de === 1'b1) begin
        if (first_de < 0) begin
          first_de = k;
          fx = a.x;
          fy = a.y;
        end
        lx = a.x;
        ly = a.y;
      end
    end
    checks = checks + 1;
    if (first_de != FIRST_DE_EDGE || fx !== '0 || fy !== '0) begin
      errors = errors + 1;
      $display("FAIL first_de got edge=%0d x=%0d y=%0d exp edge=%0d x=0 y=0",
               first_de, fx, fy, FIRST_DE_EDGE);
    end
    checks = checks + 1;
    if (lx !== CW'(HA - 1) || ly !== CW'(VA - 1)) begin
      errors = errors + 1;
      $display("FAIL last_de got x=%0d y=%0d exp x=%0d y=%0d", lx, ly, HA - 1, VA - 1);
    end
    $display("test_first_frame done first_de=%0d", first_de);
  endtask

  task automatic test_two_frames();
    out_t a;
    int   hs_n, vs_n, de_n, last_fs, last_ls;
    int   fs_min, fs_max, ls_min, ls_max;
    hs_n = 0; vs_n = 0; de_n = 0; last_fs = -1; last_ls = -1;
    fs_min = 1 << 30; fs_max = 0; ls_min = 1 << 30; ls_max = 0;
    for (int k = 0; k < 2 * FRAME + 1; k++) begin
      step();
      a = sample();
      if (k < 2 * FRAME) begin
        if (a.hs === HS_POL) hs_n++;
        if (a.vs === VS_POL) vs_n++;
        if (a.de === 1'b1) de_n++;
      end
      if (a.fs === 1'b1) begin
        if (last_fs >= 0) begin
          if (k - last_fs < fs_min) fs_min = k - last_fs;
          if (k - last_fs > fs_max) fs_max = k - last_fs;
        end
        last_fs = k;
      end
      if (a.ls === 1'b1) begin
        if (last_ls >= 0) begin
          if (k - last_ls < ls_min) ls_min = k - last_ls;
          if (k - last_ls > ls_max) ls_max = k - last_ls;
        end
        last_ls = k;
      end
    end
    checks = checks + 1;
    if (fs_min != FRAME || fs_max != FRAME) begin
      errors = errors + 1;
      $display("FAIL fs_period got min=%0d max=%0d exp %0d", fs_min, fs_max, FRAME);
    end
    checks = checks + 1;
    if (ls_min != HT || ls_max != HT) begin
      errors = errors + 1;
      $display("FAIL ls_period got min=%0d max=%0d exp %0d", ls_min, ls_max, HT);
    end
    checks = checks + 1;
    if (hs_n != 2 * VT * HS) begin
      errors = errors + 1;
      $display("FAIL hsync_width got %0d exp %0d", hs_n, 2 * VT * HS);
    end
    checks = checks + 1;
    if (vs_n != 2 * VS * HT) begin
      errors = errors + 1;
      $display("FAIL vsync_width got %0d exp %0d", vs_n, 2 * VS * HT);
    end
    checks = checks + 1;
    if (de_n != 2 * HA * VA) begin
      errors = errors + 1;
      $display("FAIL de_count got %0d exp %0d", de_n, 2 * HA * VA);
    end
    $display("test_two_frames done de=%0d hs=%0d vs=%0d", de_n, hs_n, vs_n);
  endtask

  task automatic test_prefetch();
    out_t a, old;
    out_t hist[$];
    int   req_n, first_req;
    req_n = 0;
    first_req = -1;
    timing_en = 1'b0;
    step();
    timing_en = 1'b1;
    for (int k = 1; k <= FRAME + PF; k++) begin
      step();
      a = sample();
      hist.push_back(a);
      if (hist.size() > PF + 1) void'(hist.pop_front());
      if (a.req === 1'b1) begin
        req_n++;
        if (first_req < 0) first_req = k;
      end
`ifdef VGA_TIMING_PREFETCH_EN
      if (a.de === 1'b1 && hist.size() == PF + 1) begin
        old = hist[0];
        checks = checks + 1;
        if (old.req !== 1'b1 || old.rx !== a.x || old.ry !== a.y) begin
          errors = errors + 1;
          $display("FAIL req_lead got req=%b rx=%0d ry=%0d exp req=1 rx=%0d ry=%0d",
                   old.req, old.rx, old.ry, a.x, a.y);
        end
      end
`else
      old = a;
`endif
    end
`ifdef VGA_TIMING_PREFETCH_EN
    checks = checks + 1;
    if (req_n != HA * VA || first_req != FIRST_DE_EDGE - PF) begin
      errors = errors + 1;
      $display("FAIL req_count got n=%0d first=%0d exp n=%0d first=%0d",
               req_n, first_req, HA * VA, FIRST_DE_EDGE - PF);
    end
`else
    checks = checks + 1;
    if (req_n != 0 || old.rx !== '0 || old.ry !== '0) begin
      errors = errors + 1;
      $display("FAIL req_tied got n=%0d rx=%0d ry=%0d exp 0", req_n, old.rx, old.ry);
    end
`endif
    $display("test_prefetch done req_cycles=%0d first=%0d", req_n, first_req);
  endtask

  task automatic test_enable_drop();
    out_t a;
    int   target, guard;
    target = (VA0 + 2) * HT + HA0 + 2;
    timing_en = 1'b0;
    step();
    timing_en = 1'b1;
    guard = 0;
    while (run_cnt != target && guard < 4 * FRAME) begin
      step();
      guard++;
    end
    a = sample();
    checks = checks + 1;
    if (run_cnt != target || a.de !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL en_reach got de=%b cnt=%0d exp de=1 cnt=%0d", a.de, run_cnt, target);
    end
    timing_en = 1'b0;
    step();
    a = sample();
    checks = checks + 1;
    if (a !== reset_val()) begin
      errors = errors + 1;
      $display("FAIL en_drop got %h exp %h", a, reset_val());
    end
    step();
    step();
    timing_en = 1'b1;
    step();
    a = sample();
    checks = checks + 1;
    if (a.fs !== 1'b1 || a.ls !== 1'b1 || a.de !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL en_restart got fs=%b ls=%b de=%b exp fs=1 ls=1 de=0", a.fs, a.ls, a.de);
    end
    for (int k = 0; k < 3 * HT; k++) step();
    $display("test_enable_drop done t=%0t", $time);
  endtask

  task automatic test_async_reset();
    out_t a;
    int   guard;
    guard = 0;
    while (vga_de !== 1'b1 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    checks = checks + 1;
    if (vga_de !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL arst_reach got de=%b exp de=1", vga_de);
    end
    #1;
    sys_rst = 1'b1;
    #1;
    a = sample();
    checks = checks + 1;
    if (a !== reset_val()) begin
      errors = errors + 1;
      $display("FAIL arst_immediate got %h exp %h", a, reset_val());
    end
    step();
    step();
    step();
    $display("test_async_reset asserted t=%0t", $time);
    test_first_frame();
  endtask

  initial begin
    #100000;
    errors = errors + 1;
    $display("FAIL timeout got running exp finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    run_cnt   = 0;
    sys_rst   = 1'b1;
    timing_en = 1'b0;
    test_reset();
    test_first_frame();
    test_two_frames();
    test_prefetch();
    test_enable_drop();
    test_async_reset();
    test_two_frames();
    #20;
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drain got %0d pending exp 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
